// File: rtl/imem_loader.sv
// imem_loader: receives 8N1 UART bytes (16-bit big-endian length, then big-endian words)
// and writes the words into instruction memory at word addresses 0,1,2,...
module imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 9,
  parameter int MAX_WORDS    = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              load_en,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_DONE} ld_t;
  rx_t               r_rx_st, w_rx_nx;
  ld_t               r_ld_st, w_ld_nx;
  logic              r_rx_s1, r_rx_s2;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_byte_valid, r_fe;
  logic [15:0]       r_len;
  logic [31:0]       r_asm, r_wdata;
  logic [1:0]        r_bcnt, r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic              w_tick_half, w_tick, w_start, w_rej, w_last;
  logic [15:0]       w_len;
  assign w_tick_half = r_cnt == CW'(HALF - 1);
  assign w_tick      = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign w_len       = {r_len[15:8], r_shift};
  assign w_start     = r_ld_st == L_IDLE && load_en;
  assign w_rej       = r_ld_st == L_LEN_LO && load_en && r_byte_valid && w_len > 16'(MAX_WORDS);
  assign w_last      = r_waddr == ADDR_W'(r_len - 16'd1);
  always_comb begin
    w_rx_nx = r_rx_st;
    case (r_rx_st)
      R_IDLE:  w_rx_nx = r_rx_s2 ? R_IDLE : R_START;
      R_START: w_rx_nx = !w_tick_half ? R_START : (r_rx_s2 ? R_IDLE : R_DATA);
      R_DATA:  w_rx_nx = (w_tick && r_bit == 3'd7) ? R_STOP : R_DATA;
      R_STOP:  w_rx_nx = w_tick ? R_IDLE : R_STOP;
      default: w_rx_nx = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_st      <= R_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_fe         <= 1'b0;
    end else begin
      r_rx_s1      <= rx;
      r_rx_s2      <= r_rx_s1;
      r_rx_st      <= w_rx_nx;
      r_byte_valid <= 1'b0;
      r_fe         <= 1'b0;
      r_cnt        <= (r_rx_st == R_IDLE || (r_rx_st == R_START && w_tick_half) || w_tick) ? '0 : r_cnt + 1'b1;
      if (r_rx_st == R_DATA && w_tick) begin
        r_shift <= {r_rx_s2, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      if (r_rx_st == R_STOP && w_tick) begin
        r_byte_valid <= r_rx_s2;
        r_fe         <= !r_rx_s2;
      end
    end
  end
  // Dropping load_en aborts any in-progress load ahead of an arriving byte.
  always_comb begin
    w_ld_nx = r_ld_st;
    case (r_ld_st)
      L_IDLE:   w_ld_nx = load_en ? L_LEN_HI : L_IDLE;
      L_LEN_HI: w_ld_nx = !load_en ? L_IDLE : (r_byte_valid ? L_LEN_LO : L_LEN_HI);
      L_LEN_LO: w_ld_nx = !load_en ? L_IDLE : !r_byte_valid ? L_LEN_LO :
                          (w_len == 16'd0 || w_len > 16'(MAX_WORDS)) ? L_DONE : L_DATA;
      L_DATA:   w_ld_nx = !load_en ? L_IDLE : (r_we && w_last) ? L_DONE : L_DATA;
      L_DONE:   w_ld_nx = load_en ? L_DONE : L_IDLE;
      default:  w_ld_nx = L_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_st <= L_IDLE;
      r_len   <= '0;
      r_asm   <= '0;
      r_wdata <= '0;
      r_bcnt  <= '0;
      r_err   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
    end else begin
      r_ld_st <= w_ld_nx;
      r_we    <= 1'b0;
      r_err   <= w_start ? 2'b00 : r_err | {w_rej, r_fe};
      if (w_start) begin
        r_waddr <= '0;
        r_bcnt  <= '0;
      end else if (r_we) r_waddr <= r_waddr + 1'b1;
      if (r_ld_st == L_LEN_HI && r_byte_valid) r_len[15:8] <= r_shift;
      if (r_ld_st == L_LEN_LO && r_byte_valid) r_len[7:0] <= r_shift;
      if (r_ld_st == L_DATA && load_en && r_byte_valid) begin
        r_asm  <= {r_asm[23:0], r_shift};
        r_bcnt <= r_bcnt + 2'd1;
        if (r_bcnt == 2'd3) begin
          r_wdata <= {r_asm[23:0], r_shift};
          r_we    <= 1'b1;
        end
      end
    end
  end
  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign err   = r_err;
  assign busy  = r_ld_st == L_LEN_HI || r_ld_st == L_LEN_LO || r_ld_st == L_DATA;
  assign done  = r_ld_st == L_DONE;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized UART program loads checked by a write scoreboard.
module tb_imem_loader;
  localparam int CPB = 16;
  logic clk = 0, rst = 1, rx = 1, load_en = 0;
  logic we, busy, done;
  logic [8:0] waddr;
  logic [31:0] wdata;
  logic [1:0] err;
  int total = 0, bad = 0;
  typedef struct {logic [8:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t e;
  logic [31:0] wq[$];

  imem_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .load_en(load_en), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (we) begin
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_we: got waddr=%0d wdata=%h expected no write", waddr, wdata);
    end else begin
      e = exp_q.pop_front();
      chk("we_addr", 32'(waddr), 32'(e.a));
      chk("we_data", wdata, e.d);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic good = 1'b1);
    logic [9:0] f;
    f = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(8'(w >> (8 * i)));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 * CPB && !done; i++) @(negedge clk);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic release_load();
    load_en = 1'b0;
    @(negedge clk);
    chk("done_cleared", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("writes_all_seen", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Reference: a length in 1..512 writes the given words at addresses 0..n-1; otherwise nothing.
  task automatic load_words(input int n);
    logic [15:0] len;
    len = 16'(n);
    load_en = 1'b1;
    @(negedge clk);
    chk("busy_rise", 32'(busy), 32'd1);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    if (n >= 1 && n <= 512)
      foreach (wq[k]) begin
        exp_q.push_back('{a: 9'(k), d: wq[k]});
        send_word(wq[k]);
      end
    wait_done();
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("err_after_load", 32'(err), (n > 512) ? 32'd2 : 32'd0);
    release_load();
  endtask

  initial begin
    int m;
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    wq.delete();
    wq.push_back(32'h12345678);
    wq.push_back(32'hDEADBEEF);
    load_words(2);
    for (int r = 0; r < 4; r++) begin
      wq.delete();
      m = $urandom_range(1, 4);
      for (int k = 0; k < m; k++) wq.push_back($urandom);
      load_words(m);
    end
    wq.delete();
    load_words(513);
    load_words(0);
    // framing error on the first data byte, then a resent good word
    load_en = 1'b1;
    @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'($urandom), 1'b0);
    chk("framing_err", 32'(err), 32'd1);
    chk("framing_busy", 32'(busy), 32'd1);
    wq.delete();
    wq.push_back($urandom);
    exp_q.push_back('{a: 9'd0, d: wq[0]});
    send_word(wq[0]);
    wait_done();
    chk("framing_err_sticky", 32'(err), 32'd1);
    release_load();
    // abort after two data bytes
    load_en = 1'b1;
    @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    load_en = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    wq.delete();
    wq.push_back($urandom);
    load_words(1);
    // short glitch while waiting for the length
    load_en = 1'b1;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_err", 32'(err), 32'd0);
    chk("glitch_busy", 32'(busy), 32'd1);
    wq.delete();
    wq.push_back($urandom);
    exp_q.push_back('{a: 9'd0, d: wq[0]});
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(wq[0]);
    wait_done();
    chk("glitch_load_err", 32'(err), 32'd0);
    release_load();
    // reset mid-byte while loading
    load_en = 1'b1;
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_we", 32'(we), 0);
    chk("midrst_waddr", 32'(waddr), 0);
    chk("midrst_wdata", wdata, 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_err", 32'(err), 0);
    @(negedge clk);
    rx = 1'b1;
    load_en = 1'b0;
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_wdata", wdata, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
